// File: rtl/neuron_mac_pkg.sv
// neuron_mac_pkg: shared FSM encoding and saturating arithmetic for the neuron MAC.
package neuron_mac_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
  // Wide enough to hold the exact sum of two operands up to 2*data_width <= 126 bits
  typedef logic signed [127:0] wide_t;
  function automatic wide_t sat_max(int w);
    return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
  endfunction
  function automatic wide_t sat_min(int w);
    return ~sat_max(w);
  endfunction
  function automatic wide_t sat_add(wide_t a, wide_t b, int w);
    wide_t s;
    s = a + b;
    return s > sat_max(w) ? sat_max(w) : s < sat_min(w) ? sat_min(w) : s;
  endfunction
endpackage

// File: rtl/neuron_mac_if.sv
// neuron_mac_if: parameter-write, activation-in and sum-out handshakes of the neuron MAC.
interface neuron_mac_if #(parameter int data_width = 16, parameter int addr_width = 2);
  logic                          w_wr_en;
  logic [addr_width-1:0]         w_addr;
  logic signed [data_width-1:0]  w_data;
  logic                          bias_wr_en;
  logic signed [2*data_width-1:0] bias_data;
  logic                          in_valid;
  logic                          in_ready;
  logic signed [data_width-1:0]  in_data;
  logic                          sum_valid;
  logic                          sum_ready;
  logic signed [2*data_width-1:0] sum;
  modport master (output w_wr_en, w_addr, w_data, bias_wr_en, bias_data, in_valid, in_data, sum_ready,
                  input in_ready, sum_valid, sum);
  modport slave (input w_wr_en, w_addr, w_data, bias_wr_en, bias_data, in_valid, in_data, sum_ready,
                 output in_ready, sum_valid, sum);
endinterface

// File: rtl/neuron_weight_mem.sv
// neuron_weight_mem: weight register array with one write port and an asynchronous read port.
module neuron_weight_mem #(
  parameter int data_width = 16,
  parameter int num_inputs = 4,
  parameter int addr_width = $clog2(num_inputs)
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [addr_width-1:0]        wr_addr,
  input  logic signed [data_width-1:0] wr_data,
  input  logic [addr_width-1:0]        rd_addr,
  output logic signed [data_width-1:0] rd_data
);
  logic signed [data_width-1:0] mem [num_inputs];
  always_ff @(posedge clk)
    if (wr_en && 32'(wr_addr) < num_inputs) mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/neuron_mac.sv
// neuron_mac: streams activations against stored weights and presents the saturated biased sum.
module neuron_mac
  import neuron_mac_pkg::*;
#(
  parameter int data_width = 16,
  parameter int num_inputs = 4,
  parameter int addr_width = $clog2(num_inputs)
) (
  input logic       clk,
  input logic       rst_n,
  neuron_mac_if.slave bus
);
  localparam int sw = 2 * data_width;
  state_t state;
  logic [addr_width-1:0] cnt;
  logic signed [sw-1:0] prod, acc, bias, product, acc_add;
  logic signed [data_width-1:0] wt;
  logic prod_vld, rdy, sum_vld, xfer, last;
  neuron_weight_mem #(.data_width(data_width), .num_inputs(num_inputs), .addr_width(addr_width)) u_mem (
    .clk(clk),
    .wr_en(bus.w_wr_en && state == IDLE),
    .wr_addr(bus.w_addr),
    .wr_data(bus.w_data),
    .rd_addr(cnt),
    .rd_data(wt)
  );
  always_comb begin
    xfer = bus.in_valid && rdy;
    last = cnt == addr_width'(num_inputs - 1);
    product = sw'(bus.in_data) * sw'(wt);
    acc_add = sw'(sat_add(wide_t'(acc), wide_t'(prod), sw));
  end
  assign bus.in_ready = rdy;
  assign bus.sum_valid = sum_vld;
  assign bus.sum = acc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      prod <= '0;
      prod_vld <= 1'b0;
      acc <= '0;
      bias <= '0;
      rdy <= 1'b1;
      sum_vld <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          acc <= bias;
          if (bus.bias_wr_en) bias <= bus.bias_data;
          if (xfer) begin
            prod <= product;
            prod_vld <= 1'b1;
            cnt <= addr_width'(1);
            state <= ACCUM;
          end
        end
        ACCUM: begin
          // A product registered on the previous edge is folded in exactly once
          if (prod_vld) acc <= acc_add;
          prod_vld <= xfer;
          if (xfer) begin
            prod <= product;
            cnt <= last ? '0 : cnt + 1'b1;
            if (last) begin
              state <= DRAIN;
              rdy <= 1'b0;
            end
          end
        end
        DRAIN: begin
          acc <= acc_add;
          prod_vld <= 1'b0;
          state <= DONE;
          sum_vld <= 1'b1;
        end
        DONE: begin
          if (bus.sum_ready) begin
            state <= IDLE;
            sum_vld <= 1'b0;
            rdy <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: directed and randomized vectors against a per-step saturating arithmetic model.
module tb_neuron_mac;
  localparam int N = 4;
  localparam int DW = 16;
  localparam longint HI = 64'sd2147483647;
  localparam longint LO = -64'sd2147483648;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  longint mw[N];
  longint mb;
  longint xv[N];
  neuron_mac_if #(.data_width(DW), .addr_width(2)) bus ();
  neuron_mac #(.data_width(DW), .num_inputs(N), .addr_width(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic longint sat(longint v);
    return v > HI ? HI : v < LO ? LO : v;
  endfunction
  function automatic logic [31:0] model(input longint xs[N]);
    longint a = mb;
    for (int i = 0; i < N; i++) a = sat(a + mw[i] * xs[i]);
    return 32'(a);
  endfunction
  task automatic wr_w(input int i, input longint v);
    bus.w_wr_en = 1'b1;
    bus.w_addr = 2'(i);
    bus.w_data = 16'(v);
    tick;
    bus.w_wr_en = 1'b0;
    mw[i] = v;
  endtask
  task automatic wr_ws(input longint a, input longint b, input longint c, input longint d);
    wr_w(0, a);
    wr_w(1, b);
    wr_w(2, c);
    wr_w(3, d);
  endtask
  task automatic wr_b(input longint v);
    bus.bias_wr_en = 1'b1;
    bus.bias_data = 32'(v);
    tick;
    bus.bias_wr_en = 1'b0;
    mb = v;
  endtask
  task automatic send(input longint x);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data = 16'(x);
    while (!bus.in_ready && t < 20) begin
      tick;
      t++;
    end
    if (!bus.in_ready) chk("accept_timeout", {31'b0, bus.in_ready}, 32'd1);
    tick;
    bus.in_valid = 1'b0;
  endtask
  task automatic finish(input string tag, input logic [31:0] exp, input int hold);
    chk({tag, "_drain_valid"}, {31'b0, bus.sum_valid}, 32'd0);
    tick;
    chk({tag, "_latency_valid"}, {31'b0, bus.sum_valid}, 32'd1);
    chk({tag, "_sum"}, bus.sum, exp);
    chk({tag, "_in_ready_done"}, {31'b0, bus.in_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      tick;
      chk({tag, "_hold_sum"}, bus.sum, exp);
      chk({tag, "_hold_valid"}, {31'b0, bus.sum_valid}, 32'd1);
      chk({tag, "_hold_in_ready"}, {31'b0, bus.in_ready}, 32'd0);
    end
    bus.sum_ready = 1'b1;
    tick;
    bus.sum_ready = 1'b0;
    chk({tag, "_valid_after_hs"}, {31'b0, bus.sum_valid}, 32'd0);
    chk({tag, "_in_ready_after_hs"}, {31'b0, bus.in_ready}, 32'd1);
  endtask
  task automatic run(input string tag, input longint xs[N], input int gap, input int hold);
    logic [31:0] exp;
    exp = model(xs);
    bus.sum_ready = (hold == 0);
    for (int i = 0; i < N; i++) begin
      send(xs[i]);
      if (i < N - 1) repeat ($urandom_range(gap, 0)) tick;
    end
    finish(tag, exp, hold);
  endtask
  initial begin
    logic [31:0] exp;
    logic signed [15:0] r;
    bus.w_wr_en = 1'b0;
    bus.w_addr = '0;
    bus.w_data = '0;
    bus.bias_wr_en = 1'b0;
    bus.bias_data = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.sum_ready = 1'b0;
    tick;
    tick;
    chk("reset_sum_valid", {31'b0, bus.sum_valid}, 32'd0);
    chk("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("reset_sum", bus.sum, 32'd0);
    rst_n = 1'b1;
    tick;
    wr_ws(1, 2, 3, 4);
    wr_b(5);
    xv = '{1, 1, 1, 1};
    run("basic", xv, 0, 0);
    run("stall", xv, 3, 5);
    wr_ws(32767, 32767, 32767, 32767);
    wr_b(HI);
    xv = '{32767, 32767, 32767, 32767};
    run("sat_pos", xv, 0, 1);
    wr_ws(-32768, -32768, -32768, -32768);
    wr_b(LO);
    run("sat_neg", xv, 1, 1);
    wr_ws(-2, 3, 0, 1);
    wr_b(0);
    xv = '{5, -4, 9, 2};
    run("mixed", xv, 0, 2);
    wr_ws(1, 2, 3, 4);
    wr_b(5);
    xv = '{1, 1, 1, 1};
    exp = model(xv);
    send(1);
    bus.w_wr_en = 1'b1;
    bus.w_addr = 2'd0;
    bus.w_data = 16'd100;
    bus.bias_wr_en = 1'b1;
    bus.bias_data = 32'd1000;
    send(1);
    bus.w_wr_en = 1'b0;
    bus.bias_wr_en = 1'b0;
    send(1);
    send(1);
    finish("gate", exp, 2);
    run("gate_after", xv, 0, 0);
    send(7);
    send(3);
    rst_n = 1'b0;
    #2;
    chk("midrst_sum_valid", {31'b0, bus.sum_valid}, 32'd0);
    chk("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("midrst_sum", bus.sum, 32'd0);
    tick;
    rst_n = 1'b1;
    mb = 0;
    tick;
    run("post_rst", xv, 0, 1);
    wr_b(100);
    xv = '{2, 3, 4, 5};
    run("b2b_1", xv, 0, 0);
    wr_b(-50);
    run("b2b_2", xv, 0, 0);
    repeat (12) begin
      for (int i = 0; i < N; i++) begin
        r = 16'($urandom);
        wr_w(i, longint'(r));
        r = 16'($urandom);
        xv[i] = longint'(r);
      end
      wr_b(longint'(int'($urandom)));
      run("rand", xv, 3, int'($urandom_range(3, 0)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
